// File: rtl/pu_or1k_store_drain_pkg.sv
// -----------------------------------------------------------------------------
// pu_or1k_store_drain_pkg
//
// Shared memory-stage definitions. The store buffer uses them to pack its
// entries, and the store drain uses them to unpack and issue those entries.
//
//   drain_state_e  : store drain FSM states (IDLE / POP / BUS / ERR)
//   store_entry_t  : one committed store (pc, adr, dat, bsel, atomic)
//
// The entry struct is sized at the core's operand width (SD_OPERAND_WIDTH).
// Modules importing it default their width parameter to the same value.
// -----------------------------------------------------------------------------
package pu_or1k_store_drain_pkg;

    localparam int SD_OPERAND_WIDTH = 32;
    localparam int SD_BSEL_WIDTH    = SD_OPERAND_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_BUS  = 2'd2,
        ST_ERR  = 2'd3
    } drain_state_e;

    typedef struct packed {
        logic [SD_OPERAND_WIDTH-1:0] pc;
        logic [SD_OPERAND_WIDTH-1:0] adr;
        logic [SD_OPERAND_WIDTH-1:0] dat;
        logic [SD_BSEL_WIDTH-1:0]    bsel;
        logic                        atomic;
    } store_entry_t;

endpackage

// File: rtl/pu_or1k_store_drain.sv
// -----------------------------------------------------------------------------
// pu_or1k_store_drain
//
// Drains committed stores from the store buffer FIFO, one at a time, and
// issues each one as a single data-bus write. It also resolves l.swa against
// the reservation, and it latches the PC and address of a store that takes a
// bus error.
//
// Per store: pop (IDLE or BUS) -> capture (POP) -> bus cycle (BUS, >= 1 cycle).
// With a zero-wait ack the next pop overlaps the ack cycle. Throughput is
// then one store every 2 cycles.
//
// Ports
//   clk, rst             core clock, synchronous active-high reset
//   sb_empty_i           store buffer empty
//   sb_read_o            pop strobe (entry valid on sb_*_i the next cycle)
//   sb_pc/adr/dat/bsel/atomic_i   popped entry fields
//   atomic_reserve_i     reservation still held (sampled in POP only)
//   dbus_req_o/we_o      bus request / write enable (identical)
//   dbus_adr/dat/bsel_o  bus address, write data, byte selects
//   dbus_ack_i/err_i     bus acknowledge / error (err wins)
//   err_clear_i          exception taken, leave ERR
//   atomic_ok_o          pulse, cycle after an atomic store was acked
//   atomic_fail_o        pulse, cycle after an atomic store was discarded
//   store_err_o          level, high while in ERR
//   store_err_pc/adr_o   PC and address of the faulting store
//   busy_o               drain active or store buffer non-empty
// -----------------------------------------------------------------------------
module pu_or1k_store_drain
    import pu_or1k_store_drain_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = SD_OPERAND_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,

    input  logic                              sb_empty_i,
    output logic                              sb_read_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_pc_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   sb_dat_i,
    input  logic [OPTION_OPERAND_WIDTH/8-1:0] sb_bsel_i,
    input  logic                              sb_atomic_i,
    input  logic                              atomic_reserve_i,

    output logic                              dbus_req_o,
    output logic                              dbus_we_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
    input  logic                              dbus_ack_i,
    input  logic                              dbus_err_i,

    input  logic                              err_clear_i,
    output logic                              atomic_ok_o,
    output logic                              atomic_fail_o,
    output logic                              store_err_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_pc_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   store_err_adr_o,
    output logic                              busy_o
);

    drain_state_e state;
    drain_state_e state_next;
    store_entry_t entry;            // store currently being issued

    logic bus_done;                 // clean ack on the bus this cycle
    logic bus_fault;                // bus error this cycle (beats a same-cycle ack)
    logic atomic_discard;           // l.swa with no reservation left

    assign bus_fault      = (state == ST_BUS) && dbus_err_i;
    assign bus_done       = (state == ST_BUS) && dbus_ack_i && !dbus_err_i;
    assign atomic_discard = (state == ST_POP) && sb_atomic_i && !atomic_reserve_i;

    // Next state and pop strobe.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        state_next = state;
        sb_read_o  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!sb_empty_i) begin
                    sb_read_o  = 1'b1;
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                state_next = atomic_discard ? ST_IDLE : ST_BUS;
            end
            ST_BUS: begin
                if (dbus_err_i) begin
                    state_next = ST_ERR;
                end else if (dbus_ack_i) begin
                    // Overlap the next pop with the ack so that a zero-wait bus sustains one store per 2 cycles.
                    if (!sb_empty_i) begin
                        sb_read_o  = 1'b1;
                        state_next = ST_POP;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                if (err_clear_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Keep the store buffer untouched while the drain is held in reset.
        if (rst) sb_read_o = 1'b0;
    end

    // State, captured entry, pulses and error capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register here samples pre-edge values.
        if (rst) begin
            state           <= ST_IDLE;
            // NOTE: the capture register is reset because it drives the bus outputs directly, and those must read zero out of reset.
            entry           <= '0;
            atomic_ok_o     <= 1'b0;
            atomic_fail_o   <= 1'b0;
            store_err_pc_o  <= '0;
            store_err_adr_o <= '0;
        end else begin
            state         <= state_next;
            atomic_ok_o   <= bus_done && entry.atomic;
            atomic_fail_o <= atomic_discard;

            // The entry popped last cycle is valid on sb_*_i only now.
            if (state == ST_POP) begin
                entry <= '{pc:     sb_pc_i,
                           adr:    sb_adr_i,
                           dat:    sb_dat_i,
                           bsel:   sb_bsel_i,
                           atomic: sb_atomic_i};
            end

            if (bus_fault) begin
                store_err_pc_o  <= entry.pc;
                store_err_adr_o <= entry.adr;
            end
        end
    end

    // The bus is driven straight from the capture register, so the address, data and
    // byte selects hold stable for the whole bus cycle.
    assign dbus_req_o  = (state == ST_BUS);
    assign dbus_we_o   = dbus_req_o;
    assign dbus_adr_o  = entry.adr;
    assign dbus_dat_o  = entry.dat;
    assign dbus_bsel_o = entry.bsel;

    assign store_err_o = (state == ST_ERR);
    assign busy_o      = (state != ST_IDLE) || !sb_empty_i;

endmodule

// File: doc/pu_or1k_store_drain.md
Name: pu_or1k_store_drain

Overview:
- Sits directly downstream of the store buffer FIFO in the memory stage.
- Pops committed stores one at a time and issues each as a single Wishbone-style data-bus write.
- Resolves atomic (l.swa) stores against the current reservation.
- Reports bus errors with the faulting store's PC and address, and provides a busy flag for msync/pipeline drain.

Parameters:
- OPTION_OPERAND_WIDTH, 32, address/data width; byte-select width is OPTION_OPERAND_WIDTH/8.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- sb_empty_i  in  1  store buffer empty flag.
- sb_read_o  out  1  pop strobe to store buffer.
- sb_pc_i  in  OW  PC of entry (valid cycle after pop).
- sb_adr_i  in  OW  address of entry.
- sb_dat_i  in  OW  data of entry.
- sb_bsel_i  in  OW/8  byte selects of entry.
- sb_atomic_i  in  1  entry is an atomic store.
- atomic_reserve_i  in  1  reservation still valid.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  write enable (=dbus_req_o).
- dbus_adr_o  out  OW  bus address.
- dbus_dat_o  out  OW  bus write data.
- dbus_bsel_o  out  OW/8  bus byte selects.
- dbus_ack_i  in  1  bus acknowledge.
- dbus_err_i  in  1  bus error.
- err_clear_i  in  1  exception taken, leave ERR state.
- atomic_ok_o  out  1  one-cycle pulse: atomic store completed on bus.
- atomic_fail_o  out  1  one-cycle pulse: atomic store discarded (no reservation).
- store_err_o  out  1  level, high in ERR state.
- store_err_pc_o  out  OW  PC of faulting store.
- store_err_adr_o  out  OW  address of faulting store.
- busy_o  out  1  state!=IDLE or !sb_empty_i.

Behaviour:
- Store-buffer read timing: entry popped with sb_read_o in cycle N appears on sb_*_i in cycle N+1 and must be captured into local regs in N+1.
- States: IDLE, POP, BUS, ERR.
- IDLE:
  - sb_read_o = !sb_empty_i (combinational).
  - If !sb_empty_i -> POP.
- POP:
  - Capture pc/adr/dat/bsel/atomic.
  - If sb_atomic_i && !atomic_reserve_i: pulse atomic_fail_o, no bus cycle; -> IDLE.
  - Otherwise -> BUS; dbus_req_o/dbus_we_o asserted from the next cycle, driven from captured regs.
- BUS:
  - Hold req, adr, dat, bsel stable until ack or err.
  - ack: drop req next cycle. Pulse atomic_ok_o if captured atomic. If !sb_empty_i, assert sb_read_o this cycle and -> POP (back-to-back); else -> IDLE.
  - err (has priority over simultaneous ack): latch store_err_pc_o/store_err_adr_o; -> ERR; no pop.
- ERR:
  - store_err_o=1, no pops, req low.
  - err_clear_i -> IDLE.
  - Entries still in the store buffer are then drained normally; pipeline flush is the owner's job.
- Minimum per store: 1 pop cycle + 1 capture cycle + ≥1 bus cycle. Throughput with zero-wait ack: one store per 2 cycles.
- sb_read_o is never asserted when sb_empty_i=1, nor in POP or ERR.
- Reset values: state=IDLE; dbus_req_o, dbus_we_o, sb_read_o, atomic_ok_o, atomic_fail_o, store_err_o = 0; dbus_adr_o, dbus_dat_o, dbus_bsel_o, store_err_pc_o, store_err_adr_o = 0.
- Reset mid-transaction: req drops at the next edge; the in-flight store is lost. The bus slave must tolerate an abandoned cycle.
- atomic_reserve_i is sampled only in POP; later changes do not affect the issued store.

Decomposition:
- Shared memory-stage package: state enum (IDLE/POP/BUS/ERR) and the store-entry struct (pc, adr, dat, bsel, atomic), also reused by the store buffer packing.
- Single module, no sub-module; the FSM and capture regs are small.

Test Plan:
- Single store adr=0x1000, dat=0xDEADBEEF, bsel=0xF, ack after 3 wait cycles -> pop once; req high 4 cycles with stable adr/dat; busy_o falls the cycle after ack.
- Three queued stores with zero-wait ack -> pops spaced 2 cycles apart; bus sees adr 0x0,0x4,0x8 in order; no duplicate or missing write.
- Atomic store with atomic_reserve_i=0 -> atomic_fail_o pulse 1 cycle, no dbus_req_o. With reserve=1 -> bus write, then atomic_ok_o pulse on ack cycle+1.
- err on store pc=0x2000, adr=0x3000, with ack also high -> store_err_o=1, err_pc=0x2000, err_adr=0x3000, no pops while 2 entries are queued; err_clear_i -> remaining 2 drained.
- rst asserted while req high -> next cycle req=0, state IDLE, all outputs 0; with sb_empty_i=0, pop resumes after rst deasserts.
